// File: rtl/room_path_monitor.sv
// Watches the room-navigation FSM state: reports room changes, counts visits,
// raises a dwell alarm and logs transitions into a small FWFT history FIFO.
module room_path_monitor #(
  parameter int DWELL_MAX  = 16,
  parameter int HIST_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  output logic             trans_valid,
  output logic [2:0]       from_room,
  output logic [2:0]       to_room,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] visit_cnt,
  output logic [7:0]       dwell,
  output logic             stuck,
  output logic             hist_valid,
  output logic [5:0]       hist_data,
  input  logic             hist_ready,
  output logic             hist_ovf,
  input  logic             clr_ovf
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam logic [7:0] DWELL_TH = 8'(DWELL_MAX);

  typedef enum logic {WATCH, STUCK} alarm_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc_dwell(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  logic [2:0]       prev_room;
  logic             trans_det;
  logic [7:0]       dwell_nxt;
  alarm_t           alarm_q, alarm_d;
  logic [CNT_W-1:0] cnt [8];

  logic [5:0]       mem [HIST_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, pop, push_ok, drop;

  assign trans_det = (state != prev_room);
  assign dwell_nxt = trans_det ? 8'd0 : sat_inc_dwell(dwell);

  // detect stage: change sampled this edge is presented one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_room   <= 3'd0;
      trans_valid <= 1'b0;
      from_room   <= 3'd0;
      to_room     <= 3'd0;
      dwell       <= 8'd0;
    end else begin
      prev_room   <= state;
      trans_valid <= trans_det;
      from_room   <= prev_room;
      to_room     <= state;
      dwell       <= dwell_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else if (trans_det) begin
      cnt[state] <= sat_inc_cnt(cnt[state]);
    end
  end

  assign visit_cnt = cnt[cnt_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm_q <= WATCH;
    else     alarm_q <= alarm_d;
  end

  // A transition always wins over the threshold in the same cycle.
  always_comb begin
    alarm_d = alarm_q;
    stuck   = (alarm_q == STUCK);
    if (trans_det)
      alarm_d = WATCH;
    else if (alarm_q == WATCH && dwell_nxt >= DWELL_TH)
      alarm_d = STUCK;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = !fifo_empty && hist_ready;
  assign push_ok    = trans_det && (!fifo_full || pop);
  assign drop       = trans_det && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      hist_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)         hist_ovf <= 1'b1;
      else if (clr_ovf) hist_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= {prev_room, state};
  end

  // Head is masked while empty so stale storage never shows after reset.
  assign hist_valid = !fifo_empty;
  assign hist_data  = fifo_empty ? 6'd0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_room_path_monitor.sv
// Scoreboard bench for room_path_monitor: directed scenarios plus random room
// sequences checked against a queue/array reference model.
module tb_room_path_monitor;

  localparam int DM   = 16;
  localparam int HD   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    state = 3'd0;
  logic [2:0]    cnt_sel = 3'd0;
  logic          hist_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          trans_valid;
  logic [2:0]    from_room, to_room;
  logic [CW-1:0] visit_cnt;
  logic [7:0]    dwell;
  logic          stuck, hist_valid, hist_ovf;
  logic [5:0]    hist_data;

  int checks = 0;
  int failures = 0;

  room_path_monitor #(.DWELL_MAX(DM), .HIST_DEPTH(HD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .state(state), .trans_valid(trans_valid),
    .from_room(from_room), .to_room(to_room), .cnt_sel(cnt_sel),
    .visit_cnt(visit_cnt), .dwell(dwell), .stuck(stuck),
    .hist_valid(hist_valid), .hist_data(hist_data), .hist_ready(hist_ready),
    .hist_ovf(hist_ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int f; int t; } pair_t;

  // Reference model state
  int         m_prev = 0;
  bit         m_tv = 0;
  int         m_dwell = 0;
  int         m_cnt [8] = '{default: 0};
  bit         m_ovf = 0;
  logic [5:0] m_fifo [$];
  pair_t      exp_q [$];
  bit         tr, dropped;
  pair_t      got;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 0; m_tv = 0; m_dwell = 0; m_ovf = 0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_fifo.delete();
      exp_q.delete();
    end else begin
      tr = (int'(state) != m_prev);
      dropped = 0;
      if (m_fifo.size() > 0 && hist_ready) void'(m_fifo.pop_front());
      if (tr) begin
        exp_q.push_back('{m_prev, int'(state)});
        if (m_cnt[state] < CMAX) m_cnt[state]++;
        if (m_fifo.size() < HD) m_fifo.push_back({3'(m_prev), state});
        else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_dwell = tr ? 0 : ((m_dwell < 255) ? m_dwell + 1 : 255);
      m_tv = tr;
      m_prev = int'(state);
    end
  end

  // Monitor: samples on the falling edge, pops the transition queue on pulses.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_trans_valid", trans_valid, 0);
      chk("rst_from_to", {from_room, to_room}, 0);
      chk("rst_dwell", dwell, 0);
      chk("rst_stuck", stuck, 0);
      chk("rst_hist_valid", hist_valid, 0);
      chk("rst_hist_data", hist_data, 0);
      chk("rst_hist_ovf", hist_ovf, 0);
      chk("rst_visit_cnt", visit_cnt, 0);
    end else begin
      chk("trans_valid", trans_valid, m_tv);
      if (trans_valid || m_tv) begin
        if (exp_q.size() == 0) begin
          chk("trans_queue_nonempty", 0, 1);
        end else begin
          got = exp_q.pop_front();
          if (trans_valid) begin
            chk("from_room", from_room, got.f);
            chk("to_room", to_room, got.t);
          end
        end
      end
      chk("dwell", dwell, m_dwell);
      chk("stuck", stuck, (m_dwell >= DM) ? 1 : 0);
      chk("visit_cnt", visit_cnt, m_cnt[cnt_sel]);
      chk("hist_valid", hist_valid, (m_fifo.size() > 0) ? 1 : 0);
      if (m_fifo.size() > 0) chk("hist_data", hist_data, m_fifo[0]);
      chk("hist_ovf", hist_ovf, m_ovf);
    end
  end

  task automatic step(input int s, input bit rdy, input bit clr);
    @(negedge clk);
    #1;
    state      = 3'(s);
    hist_ready = rdy;
    clr_ovf    = clr;
    cnt_sel    = 3'($urandom_range(0, 7));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int s;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // path 0,1,4,5
    step(0, 1, 0); step(1, 1, 0); step(4, 1, 0); step(5, 1, 0);
    repeat (8) step(5, 1, 0);

    // long dwell: alarm and saturation, then leave
    repeat (300) step(3, 1, 0);
    repeat (3) step(0, 1, 0);

    // overflow with consumer stalled, then clear
    step(1, 0, 0); step(2, 0, 0); step(3, 0, 0); step(4, 0, 0); step(5, 0, 0);
    step(5, 0, 0); step(5, 0, 1); step(5, 0, 0);
    // full FIFO with push and pop together
    step(6, 1, 0); step(6, 0, 0); step(6, 0, 0);
    repeat (6) step(6, 1, 0);

    // visit counter saturation
    for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 7 : 6, 1, 0);

    // random traffic
    s = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 7);
      step(s, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end

    // mid-operation reset with pending entries and alarm raised
    repeat (6) step(0, 1, 0);
    step(1, 0, 0); step(2, 0, 0); step(3, 0, 0);
    repeat (20) step(3, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    state = 3'd0;
    #1;
    chk("async_rst_trans_valid", trans_valid, 0);
    chk("async_rst_stuck", stuck, 0);
    chk("async_rst_dwell", dwell, 0);
    chk("async_rst_hist_valid", hist_valid, 0);
    chk("async_rst_hist_data", hist_data, 0);
    chk("async_rst_hist_ovf", hist_ovf, 0);
    chk("async_rst_visit_cnt", visit_cnt, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    step(0, 1, 0); step(2, 1, 0); step(5, 1, 0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 7);
      step(s, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end
    repeat (3) step(s, 1, 0);
    @(negedge clk);
    #1;
    chk("trans_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
